fetch_unit_bp: RTL and testbench

Parametrised multi-issue instruction fetch stage with an integrated direct-mapped branch target buffer (BTB) using 2-bit saturating counters. It sits between the instruction memory and decode. It owns the architectural fetch PC and issues FETCH_W consecutive instructions per cycle. It truncates a bundle after the first predicted-taken slot, and it accepts redirects and BTB training from the branch-resolution unit. The fetch-to-decode pipeline register and its valid/ready handshake live inside this block.

---
 rtl/fetch_unit_bp_pkg.sv | 27 ++
 rtl/fetch_unit_bp_btb_2bit.sv | 65 ++++++
 rtl/fetch_unit_bp.sv | 108 ++++++++++
 tb/tb_fetch_unit_bp.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_bp_pkg.sv
// Shared types, counter constants and width helpers for the fetch stage and its BTB.
package fetch_unit_bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'd0;
  localparam ctr_t CTR_WNT = 2'd1;
  localparam ctr_t CTR_WT  = 2'd2;
  localparam ctr_t CTR_ST  = 2'd3;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int pc_w, input int entries);
    return pc_w - $clog2(entries);
  endfunction

  // Saturating 2-bit direction counter step.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken)
      return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
    else
      return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/fetch_unit_bp_btb_2bit.sv
// Direct-mapped BTB with 2-bit counters: FETCH_W combinational lookups, one training port.
module btb_2bit
  import fetch_unit_bp_pkg::*;
#(
  parameter int PC_W        = 16,
  parameter int BTB_ENTRIES = 16,
  parameter int FETCH_W     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FETCH_W*PC_W-1:0] look_pc,
  output logic [FETCH_W-1:0]      look_taken,
  output logic [FETCH_W*PC_W-1:0] look_target,
  input  logic                    upd_valid,
  input  logic [PC_W-1:0]         upd_pc,
  input  logic                    upd_taken,
  input  logic [PC_W-1:0]         upd_target
);

  localparam int IDX_W = idx_w(BTB_ENTRIES);
  localparam int TAG_W = tag_w(PC_W, BTB_ENTRIES);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    ctr_t             ctr;
  } btb_entry_t;

  btb_entry_t mem_q [BTB_ENTRIES];

  for (genvar g = 0; g < FETCH_W; g++) begin : g_rd
    logic [PC_W-1:0] lpc;
    btb_entry_t      ent;
    assign lpc = look_pc[g*PC_W +: PC_W];
    assign ent = mem_q[lpc[IDX_W-1:0]];
    assign look_taken[g] = ent.valid && (ent.tag == lpc[PC_W-1:IDX_W]) && ent.ctr[1];
    assign look_target[g*PC_W +: PC_W] = ent.target;
  end

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;

  assign upd_idx = upd_pc[IDX_W-1:0];
  assign upd_tag = upd_pc[PC_W-1:IDX_W];
  assign upd_hit = mem_q[upd_idx].valid && (mem_q[upd_idx].tag == upd_tag);

  // Lookups read mem_q directly, so a same-cycle update is only seen next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        mem_q[upd_idx].ctr <= ctr_next(mem_q[upd_idx].ctr, upd_taken);
        if (upd_taken) mem_q[upd_idx].target <= upd_target;
      end else if (upd_taken) begin
        mem_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target, ctr: CTR_WT};
      end
    end
  end

endmodule

// File: rtl/fetch_unit_bp.sv
// Multi-issue fetch stage: owns the fetch PC, BTB-driven next-PC selection and the fetch/decode register.
module fetch_unit_bp
  import fetch_unit_bp_pkg::*;
#(
  parameter int              PC_W        = 16,
  parameter int              INSTR_W     = 32,
  parameter int              FETCH_W     = 2,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       halt,
  output logic [PC_W-1:0]            imem_addr,
  output logic                       imem_en,
  input  logic [FETCH_W*INSTR_W-1:0] imem_rdata,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  input  logic                       upd_valid,
  input  logic [PC_W-1:0]            upd_pc,
  input  logic                       upd_taken,
  input  logic [PC_W-1:0]            upd_target,
  output logic                       fd_valid,
  input  logic                       dec_ready,
  output logic [FETCH_W*INSTR_W-1:0] fd_instr,
  output logic [PC_W-1:0]            fd_pc,
  output logic [FETCH_W-1:0]         fd_slot_valid,
  output logic                       fd_pred_taken,
  output logic [PC_W-1:0]            fd_pred_target
);

  logic [PC_W-1:0]         pc_q;
  logic                    adv;
  logic [FETCH_W*PC_W-1:0] look_pc;
  logic [FETCH_W*PC_W-1:0] look_target;
  logic [FETCH_W-1:0]      look_taken;
  logic [FETCH_W-1:0]      slot_mask;
  logic                    pred_taken;
  logic [PC_W-1:0]         pred_target;
  logic [PC_W-1:0]         next_pc;

  assign adv       = !halt && !redirect_valid && (!fd_valid || dec_ready);
  assign imem_en   = adv;
  assign imem_addr = pc_q;

  for (genvar g = 0; g < FETCH_W; g++) begin : g_spc
    assign look_pc[g*PC_W +: PC_W] = pc_q + PC_W'(g);
  end

  btb_2bit #(
    .PC_W        (PC_W),
    .BTB_ENTRIES (BTB_ENTRIES),
    .FETCH_W     (FETCH_W)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .look_pc     (look_pc),
    .look_taken  (look_taken),
    .look_target (look_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  // Slots up to and including the first predicted-taken one survive.
  always_comb begin
    slot_mask   = '0;
    pred_taken  = 1'b0;
    pred_target = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (!pred_taken) begin
        slot_mask[i] = 1'b1;
        if (look_taken[i]) begin
          pred_taken  = 1'b1;
          pred_target = look_target[i*PC_W +: PC_W];
        end
      end
    end
    next_pc = pred_taken ? pred_target : pc_q + PC_W'(FETCH_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      fd_valid       <= 1'b0;
      fd_instr       <= '0;
      fd_pc          <= '0;
      fd_slot_valid  <= '0;
      fd_pred_taken  <= 1'b0;
      fd_pred_target <= '0;
    end else if (redirect_valid) begin
      pc_q     <= redirect_pc;
      fd_valid <= 1'b0;
    end else if (adv) begin
      pc_q           <= next_pc;
      fd_valid       <= 1'b1;
      fd_instr       <= imem_rdata;
      fd_pc          <= pc_q;
      fd_slot_valid  <= slot_mask;
      fd_pred_taken  <= pred_taken;
      fd_pred_target <= pred_target;
    end else if (dec_ready) begin
      fd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit_bp.sv
// Directed bench for fetch_unit_bp: vector table plus hand sequences for training, reset and wrap.
module tb_fetch_unit_bp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic [63:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [15:0] upd_target = '0;
  logic        fd_valid;
  logic        dec_ready = 1'b0;
  logic [63:0] fd_instr;
  logic [15:0] fd_pc;
  logic [1:0]  fd_slot_valid;
  logic        fd_pred_taken;
  logic [15:0] fd_pred_target;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr(input logic [15:0] a);
    return {~a, a};
  endfunction

  assign imem_rdata = {instr(imem_addr + 16'd1), instr(imem_addr)};

  fetch_unit_bp #(
    .PC_W(16), .INSTR_W(32), .FETCH_W(2), .BTB_ENTRIES(16), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .fd_valid(fd_valid), .dec_ready(dec_ready), .fd_instr(fd_instr), .fd_pc(fd_pc),
    .fd_slot_valid(fd_slot_valid), .fd_pred_taken(fd_pred_taken), .fd_pred_target(fd_pred_target)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        h, rv;
    logic [15:0] rpc;
    logic        uv;
    logic [15:0] upc;
    logic        ut;
    logic [15:0] utgt;
    logic        dr;
    logic [15:0] e_addr;
    logic        e_en, e_v;
    logic [15:0] e_pc;
    logic [1:0]  e_slot;
    logic        e_pt;
    logic [15:0] e_tgt;
  } vec_t;

  function automatic vec_t mk(
    input logic h, input logic rv, input logic [15:0] rpc,
    input logic uv, input logic [15:0] upc, input logic ut, input logic [15:0] utgt,
    input logic dr, input logic [15:0] e_addr, input logic e_en, input logic e_v,
    input logic [15:0] e_pc, input logic [1:0] e_slot, input logic e_pt, input logic [15:0] e_tgt);
    vec_t v;
    v.h = h; v.rv = rv; v.rpc = rpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.dr = dr; v.e_addr = e_addr; v.e_en = e_en; v.e_v = e_v; v.e_pc = e_pc;
    v.e_slot = e_slot; v.e_pt = e_pt; v.e_tgt = e_tgt;
    return v;
  endfunction

  task automatic idle_inputs();
    halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; dec_ready = 1'b1;
  endtask

  // Starts and ends at a falling edge.
  task automatic train(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
    idle_inputs();
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
    @(posedge clk); #1;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic probe(input string nm, input logic [15:0] pc, input logic [1:0] slot,
                       input logic pt, input logic [15:0] tgt);
    idle_inputs();
    redirect_valid = 1'b1; redirect_pc = pc;
    @(posedge clk); #1;
    chk({nm, "_flush_valid"}, {63'd0, fd_valid}, 64'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk({nm, "_addr"}, {48'd0, imem_addr}, {48'd0, pc});
    chk({nm, "_en"}, {63'd0, imem_en}, 64'd1);
    @(posedge clk); #1;
    chk({nm, "_valid"}, {63'd0, fd_valid}, 64'd1);
    chk({nm, "_pc"}, {48'd0, fd_pc}, {48'd0, pc});
    chk({nm, "_slot"}, {62'd0, fd_slot_valid}, {62'd0, slot});
    chk({nm, "_pt"}, {63'd0, fd_pred_taken}, {63'd0, pt});
    chk({nm, "_tgt"}, {48'd0, fd_pred_target}, {48'd0, tgt});
    chk({nm, "_instr"}, fd_instr, {instr(pc + 16'd1), instr(pc)});
    @(negedge clk);
  endtask

  vec_t vecs [23];

  initial begin
    //            h  rv rpc      uv upc      ut utgt     dr addr     en v  fpc      slot   pt tgt
    vecs[0]  = mk(0, 0, 16'h0,   0, 16'h0,   0, 16'h0,   1, 16'h0000, 1, 1, 16'h0000, 2'b11, 0, 16'h0);
    vecs[1]  = mk(0, 0, 16'h0,   0, 16'h0,   0, 16'h0,   1, 16'h0002, 1, 1, 16'h0002, 2'b11, 0, 16'h0);
    vecs[2]  = mk(0, 0, 16'h0,   0, 16'h0,   0, 16'h0,   1, 16'h0004, 1, 1, 16'h0004, 2'b11, 0, 16'h0);
    vecs[3]  = mk(0, 0, 16'h0,   0, 16'h0,   0, 16'h0,   1, 16'h0006, 1, 1, 16'h0006, 2'b11, 0, 16'h0);
    vecs[4]  = mk(0, 0, 16'h0,   1, 16'h5,   1, 16'h40,  0, 16'h0008, 0, 1, 16'h0006, 2'b11, 0, 16'h0);
    vecs[5]  = mk(0, 1, 16'h4,   0, 16'h0,   0, 16'h0,   0, 16'h0008, 0, 0, 16'h0006, 2'b11, 0, 16'h0);
    vecs[6]  = mk(0, 0, 16'h0,   0, 16'h0,   0, 16'h0,   1, 16'h0004, 1, 1, 16'h0004, 2'b11, 1, 16'h40);
    vecs[7]  = mk(0, 0, 16'h0,   1, 16'h4,   1, 16'h80,  1, 16'h0040, 1, 1, 16'h0040, 2'b11, 0, 16'h0);
    vecs[8]  = mk(0, 1, 16'h4,   0, 16'h0,   0, 16'h0,   1, 16'h0042, 0, 0, 16'h0040, 2'b11, 0, 16'h0);
    vecs[9]  = mk(0, 0, 16'h0,   0, 16'h0,   0, 16'h0,   1, 16'h0004, 1, 1, 16'h0004, 2'b01, 1, 16'h80);
    vecs[10] = mk(0, 0, 16'h0,   0, 16'h0,   0, 16'h0,   0, 16'h0080, 0, 1, 16'h0004, 2'b01, 1, 16'h80);
    vecs[11] = mk(0, 0, 16'h0,   0, 16'h0,   0, 16'h0,   0, 16'h0080, 0, 1, 16'h0004, 2'b01, 1, 16'h80);
    vecs[12] = mk(0, 0, 16'h0,   0, 16'h0,   0, 16'h0,   0, 16'h0080, 0, 1, 16'h0004, 2'b01, 1, 16'h80);
    vecs[13] = mk(0, 0, 16'h0,   0, 16'h0,   0, 16'h0,   1, 16'h0080, 1, 1, 16'h0080, 2'b11, 0, 16'h0);
    vecs[14] = mk(0, 0, 16'h0,   1, 16'h82,  1, 16'h200, 1, 16'h0082, 1, 1, 16'h0082, 2'b11, 0, 16'h0);
    vecs[15] = mk(0, 1, 16'h82,  0, 16'h0,   0, 16'h0,   1, 16'h0084, 0, 0, 16'h0082, 2'b11, 0, 16'h0);
    vecs[16] = mk(0, 0, 16'h0,   0, 16'h0,   0, 16'h0,   1, 16'h0082, 1, 1, 16'h0082, 2'b01, 1, 16'h200);
    vecs[17] = mk(1, 1, 16'h100, 0, 16'h0,   0, 16'h0,   0, 16'h0200, 0, 0, 16'h0082, 2'b01, 1, 16'h200);
    vecs[18] = mk(1, 0, 16'h0,   0, 16'h0,   0, 16'h0,   1, 16'h0100, 0, 0, 16'h0082, 2'b01, 1, 16'h200);
    vecs[19] = mk(0, 0, 16'h0,   0, 16'h0,   0, 16'h0,   1, 16'h0100, 1, 1, 16'h0100, 2'b11, 0, 16'h0);
    vecs[20] = mk(1, 0, 16'h0,   0, 16'h0,   0, 16'h0,   0, 16'h0102, 0, 1, 16'h0100, 2'b11, 0, 16'h0);
    vecs[21] = mk(1, 0, 16'h0,   0, 16'h0,   0, 16'h0,   1, 16'h0102, 0, 0, 16'h0100, 2'b11, 0, 16'h0);
    vecs[22] = mk(0, 0, 16'h0,   0, 16'h0,   0, 16'h0,   1, 16'h0102, 1, 1, 16'h0102, 2'b11, 0, 16'h0);

    // Reset state
    @(posedge clk); #2;
    chk("rst_valid", {63'd0, fd_valid}, 64'd0);
    chk("rst_addr", {48'd0, imem_addr}, 64'd0);
    chk("rst_pc", {48'd0, fd_pc}, 64'd0);
    chk("rst_slot", {62'd0, fd_slot_valid}, 64'd0);
    chk("rst_instr", fd_instr, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      halt = vecs[i].h; redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_taken = vecs[i].ut;
      upd_target = vecs[i].utgt; dec_ready = vecs[i].dr;
      #1;
      chk($sformatf("v%0d_addr", i), {48'd0, imem_addr}, {48'd0, vecs[i].e_addr});
      chk($sformatf("v%0d_en", i), {63'd0, imem_en}, {63'd0, vecs[i].e_en});
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), {63'd0, fd_valid}, {63'd0, vecs[i].e_v});
      chk($sformatf("v%0d_pc", i), {48'd0, fd_pc}, {48'd0, vecs[i].e_pc});
      chk($sformatf("v%0d_slot", i), {62'd0, fd_slot_valid}, {62'd0, vecs[i].e_slot});
      chk($sformatf("v%0d_pt", i), {63'd0, fd_pred_taken}, {63'd0, vecs[i].e_pt});
      chk($sformatf("v%0d_tgt", i), {48'd0, fd_pred_target}, {48'd0, vecs[i].e_tgt});
      if (vecs[i].e_v)
        chk($sformatf("v%0d_instr", i), fd_instr,
            {instr(vecs[i].e_pc + 16'd1), instr(vecs[i].e_pc)});
      @(negedge clk);
    end

    // Counter walk on 0x10: 2 -> 3 -> 3 -> 2 -> 1
    train(16'h10, 1'b1, 16'h300);
    probe("ctr2a", 16'h10, 2'b01, 1'b1, 16'h300);
    train(16'h10, 1'b1, 16'h300);
    probe("ctr3a", 16'h10, 2'b01, 1'b1, 16'h300);
    train(16'h10, 1'b1, 16'h300);
    probe("ctr3b", 16'h10, 2'b01, 1'b1, 16'h300);
    train(16'h10, 1'b0, 16'hDEAD);
    probe("ctr2b", 16'h10, 2'b01, 1'b1, 16'h300);
    train(16'h10, 1'b0, 16'hDEAD);
    probe("ctr1", 16'h10, 2'b11, 1'b0, 16'h0);

    // Miss not-taken leaves the BTB alone; miss taken evicts the aliasing entry.
    train(16'h20, 1'b0, 16'h500);
    probe("miss_nt", 16'h20, 2'b11, 1'b0, 16'h0);
    train(16'h10, 1'b1, 16'h300);
    train(16'h30, 1'b1, 16'h600);
    probe("alloc30", 16'h30, 2'b01, 1'b1, 16'h600);
    probe("evict10", 16'h10, 2'b11, 1'b0, 16'h0);

    // Asynchronous reset while a bundle is held.
    idle_inputs();
    dec_ready = 1'b0;
    @(posedge clk); #1;
    chk("held_valid", {63'd0, fd_valid}, 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, fd_valid}, 64'd0);
    chk("arst_addr", {48'd0, imem_addr}, 64'd0);
    chk("arst_pt", {63'd0, fd_pred_taken}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dec_ready = 1'b1;
    #1;
    chk("post_rst_addr", {48'd0, imem_addr}, 64'd0);
    chk("post_rst_en", {63'd0, imem_en}, 64'd1);
    @(posedge clk); #1;
    chk("post_rst_pc", {48'd0, fd_pc}, 64'd0);
    chk("post_rst_slot", {62'd0, fd_slot_valid}, 64'd3);
    @(negedge clk);
    probe("rst_miss4", 16'h4, 2'b11, 1'b0, 16'h0);
    probe("rst_miss82", 16'h82, 2'b11, 1'b0, 16'h0);
    probe("rst_miss30", 16'h30, 2'b11, 1'b0, 16'h0);

    // PC wrap at the top of the address space.
    probe("wrap", 16'hFFFF, 2'b11, 1'b0, 16'h0);
    #1;
    chk("wrap_next_addr", {48'd0, imem_addr}, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
